// File: rtl/stack_spill.sv
// Operand stack backed by a DEPTH-entry circular buffer that spills its oldest
// entries to a memory region when full-ish and fills them back when nearly empty.
module stack_spill #(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 8,
   parameter int VISIBLES   = 1,
   parameter int ADDR_WIDTH = 32,
   parameter int SPILL_MAX  = 256,
   parameter int HIGH_MARK  = DEPTH - 2,
   parameter int LOW_MARK   = 2
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                push,
   input  logic                                pop,
   input  logic [WIDTH-1:0]                    insert,
   output logic [VISIBLES-1:0][WIDTH-1:0]      tops,
   output logic                                stall,
   output logic [$clog2(DEPTH+1)-1:0]          occupancy,
   output logic [$clog2(SPILL_MAX+1)-1:0]      spilled,
   output logic                                overflow,
   output logic                                underflow,
   input  logic [ADDR_WIDTH-1:0]               base_addr,
   output logic                                mem_req,
   output logic                                mem_we,
   output logic [ADDR_WIDTH-1:0]               mem_addr,
   output logic [WIDTH-1:0]                    mem_wdata,
   input  logic                                mem_ack,
   input  logic [WIDTH-1:0]                    mem_rdata,
   output logic [1:0]                          state_dbg
);

   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam int SP_W  = $clog2(SPILL_MAX + 1);
   localparam int PTR_W = $clog2(DEPTH);

   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
   localparam logic [OCC_W-1:0] OCC_NEAR = OCC_W'(DEPTH - 1);
   localparam logic [OCC_W-1:0] OCC_HIGH = OCC_W'(HIGH_MARK);
   localparam logic [OCC_W-1:0] OCC_LOW  = OCC_W'(LOW_MARK);
   localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
   localparam logic [SP_W-1:0]  SP_MAX   = SP_W'(SPILL_MAX);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SPILL = 2'd1,
      FILL  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0] ram [DEPTH];
   logic [PTR_W-1:0] bot_ptr;
   logic [PTR_W-1:0] push_idx;
   logic [PTR_W-1:0] top_idx;
   logic [PTR_W-1:0] fill_idx;

   logic op_push, op_pop, op_rep;
   logic occ_zero, occ_full, sp_zero, sp_full;
   logic do_push, do_pop, do_rep, set_ovf, set_unf;
   logic start_spill, start_fill, spill_done, fill_done;
   logic [OCC_W-1:0] occ_nxt;
   logic [SP_W-1:0]  sp_nxt;

   assign state_dbg = state;

   // Live entries sit at bot_ptr .. bot_ptr+occupancy-1; fills land just below bot_ptr.
   assign push_idx = bot_ptr + occupancy[PTR_W-1:0];
   assign top_idx  = push_idx - PTR_W'(1);
   assign fill_idx = bot_ptr - PTR_W'(1);

   always_comb begin
      op_push  = push & ~pop;
      op_pop   = pop & ~push;
      op_rep   = push & pop;
      occ_zero = (occupancy == '0);
      occ_full = (occupancy == OCC_FULL);
      sp_zero  = (spilled == '0);
      sp_full  = (spilled == SP_MAX);

      // SPILL guards the entry whose value is already on mem_wdata; FILL keeps a slot free.
      stall = (op_push & occ_full & ~sp_full)
            | (op_pop & occ_zero & ~sp_zero)
            | ((state == SPILL) & op_pop & (occupancy <= OCC_ONE))
            | ((state == FILL) & op_push & (occupancy >= OCC_NEAR));

      do_push = ~stall & ((op_push & ~occ_full) | (op_rep & occ_zero));
      do_pop  = ~stall & op_pop & ~occ_zero;
      do_rep  = ~stall & op_rep & ~occ_zero;
      set_ovf = ~stall & op_push & occ_full & sp_full;
      set_unf = ~stall & op_pop & occ_zero & sp_zero;
   end

   // Memory handshake: mem_req and its qualifiers stay constant until the cycle
   // mem_ack is high, which completes the transfer; acks outside a transfer are ignored.
   always_comb begin
      state_nxt   = state;
      start_spill = 1'b0;
      start_fill  = 1'b0;
      spill_done  = 1'b0;
      fill_done   = 1'b0;
      case (state)
         IDLE: begin
            if ((occupancy >= OCC_HIGH) && !sp_full) begin
               start_spill = 1'b1;
               state_nxt   = SPILL;
            end else if ((occupancy <= OCC_LOW) && !sp_zero) begin
               start_fill = 1'b1;
               state_nxt  = FILL;
            end
         end
         SPILL: begin
            if (mem_ack) begin
               spill_done = 1'b1;
               state_nxt  = IDLE;
            end
         end
         FILL: begin
            if (mem_ack) begin
               fill_done = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      occ_nxt = occupancy + OCC_W'(do_push) + OCC_W'(fill_done)
              - OCC_W'(do_pop) - OCC_W'(spill_done);
      sp_nxt  = spilled + SP_W'(spill_done) - SP_W'(fill_done);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         bot_ptr   <= '0;
         occupancy <= '0;
         spilled   <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state     <= state_nxt;
         occupancy <= occ_nxt;
         spilled   <= sp_nxt;
         if (spill_done) begin
            bot_ptr <= bot_ptr + PTR_W'(1);
         end else if (fill_done) begin
            bot_ptr <= fill_idx;
         end
         if (set_ovf) begin
            overflow <= 1'b1;
         end
         if (set_unf) begin
            underflow <= 1'b1;
         end
         if (start_spill) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= base_addr + ADDR_WIDTH'(spilled);
            mem_wdata <= ram[bot_ptr];
         end else if (start_fill) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= base_addr + ADDR_WIDTH'(spilled) - ADDR_WIDTH'(1);
         end else if (spill_done || fill_done) begin
            mem_req <= 1'b0;
         end
      end
   end

   // Storage needs no reset: tops masks every slot at or above occupancy.
   always_ff @(posedge clk) begin
      if (do_push) begin
         ram[push_idx] <= insert;
      end
      if (do_rep) begin
         ram[top_idx] <= insert;
      end
      if (fill_done) begin
         ram[fill_idx] <= mem_rdata;
      end
   end

   always_comb begin
      tops = '0;
      for (int i = 0; i < VISIBLES; i++) begin
         if (i < int'(occupancy)) begin
            tops[i] = ram[top_idx - PTR_W'(i)];
         end
      end
   end

endmodule

// File: tb/tb_stack_spill.sv
// Bench for stack_spill: directed scenarios plus random traffic, checked against a
// whole-stack queue model with a simple acking memory.
module tb_stack_spill;

   localparam int W    = 32;
   localparam int D    = 8;
   localparam int V    = 2;
   localparam int AW   = 32;
   localparam int SMAX = 16;
   localparam int HIGH = 6;
   localparam int LOW  = 2;
   localparam logic [31:0] BASE = 32'h100;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 push, pop;
   logic [W-1:0]         insert;
   logic [V-1:0][W-1:0]  tops;
   logic                 stall;
   logic [3:0]           occupancy;
   logic [4:0]           spilled;
   logic                 overflow, underflow;
   logic [AW-1:0]        base_addr;
   logic                 mem_req, mem_we;
   logic [AW-1:0]        mem_addr;
   logic [W-1:0]         mem_wdata;
   logic                 mem_ack;
   logic [W-1:0]         mem_rdata;
   logic [1:0]           state_dbg;

   stack_spill #(
      .WIDTH(W), .DEPTH(D), .VISIBLES(V), .ADDR_WIDTH(AW),
      .SPILL_MAX(SMAX), .HIGH_MARK(HIGH), .LOW_MARK(LOW)
   ) dut (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .insert(insert),
      .tops(tops), .stall(stall), .occupancy(occupancy), .spilled(spilled),
      .overflow(overflow), .underflow(underflow), .base_addr(base_addr),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // scoreboard: the whole logical stack, oldest first; the first `sp` entries live in memory
   logic [W-1:0] exp_q[$];
   int           sp;
   int           ph;
   bit           m_req, m_we, m_ovf, m_unf;
   logic [31:0]  m_addr, m_wdata;
   int           lat, age;
   bit           ack_en, spur, rnd_lat;
   int           s_occ;
   logic [W-1:0] mem_arr [64];
   logic [31:0]  wr_addr_q[$], wr_data_q[$], rd_addr_q[$];

   function automatic int m_occ();
      return exp_q.size() - sp;
   endfunction

   task automatic model_clear();
      exp_q.delete();
      wr_addr_q.delete();
      wr_data_q.delete();
      rd_addr_q.delete();
      sp = 0; ph = 0; m_req = 0; m_we = 0; m_ovf = 0; m_unf = 0;
      m_addr = '0; m_wdata = '0;
      lat = 2; age = 0; ack_en = 1; spur = 0; rnd_lat = 0;
   endtask

   task automatic reset_dut();
      reset = 1'b1; push = 0; pop = 0; insert = '0;
      mem_ack = 0; mem_rdata = '0; base_addr = BASE;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_clear();
   endtask

   task automatic compare_state();
      int occ;
      logic [31:0] exp_top;
      occ = m_occ();
      check("occupancy", 64'(occupancy), 64'(occ));
      check("spilled", 64'(spilled), 64'(sp));
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("underflow", 64'(underflow), 64'(m_unf));
      check("mem_req", 64'(mem_req), 64'(m_req));
      if (m_req) begin
         check("mem_we", 64'(mem_we), 64'(m_we));
         check("mem_addr", 64'(mem_addr), 64'(m_addr));
         if (m_we) check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
      end
      for (int i = 0; i < V; i++) begin
         exp_top = (i < occ) ? exp_q[exp_q.size() - 1 - i] : '0;
         check("tops", 64'(tops[i]), 64'(exp_top));
      end
   endtask

   // driver: one clock cycle, entered and left at a falling edge
   task automatic step(input bit p, input bit q, input logic [W-1:0] v, input bit fa,
                       output bit acc, output bit dst);
      int occ, sp0;
      bit a, est;
      logic [5:0] idx;
      compare_state();
      occ = m_occ();
      a = fa;
      if (m_req) begin
         if (age == 0 && rnd_lat) lat = $urandom_range(1, 3);
         age++;
         if (ack_en && age >= lat) a = 1;
      end else begin
         age = 0;
         if (spur && $urandom_range(0, 7) == 0) a = 1;
      end
      idx = 6'(mem_addr - BASE);
      push = p; pop = q; insert = v; mem_ack = a;
      mem_rdata = $urandom();
      if (a && m_req && !m_we) mem_rdata = mem_arr[idx];
      #1;
      est = (p && !q && occ == D && sp < SMAX) || (q && !p && occ == 0 && sp > 0)
         || (ph == 1 && q && !p && occ <= 1) || (ph == 2 && p && !q && occ >= D - 1);
      check("stall", 64'(stall), 64'(est));
      dst = stall;
      acc = !est;
      s_occ = int'(occupancy);
      if (a && m_req && m_we) begin
         mem_arr[idx] = mem_wdata;
         wr_addr_q.push_back(mem_addr);
         wr_data_q.push_back(mem_wdata);
      end
      if (a && m_req && !m_we) rd_addr_q.push_back(mem_addr);
      sp0 = sp;
      if (ph == 0) begin
         if (occ >= HIGH && sp < SMAX) begin
            ph = 1; m_req = 1; m_we = 1;
            m_addr = BASE + 32'(sp); m_wdata = exp_q[sp];
         end else if (occ <= LOW && sp > 0) begin
            ph = 2; m_req = 1; m_we = 0;
            m_addr = BASE + 32'(sp - 1);
         end
      end else if (a) begin
         if (ph == 1) sp++;
         else sp--;
         ph = 0; m_req = 0;
      end
      if (!est) begin
         if (p && (!q || occ == 0)) begin
            if (occ == D && sp0 == SMAX) m_ovf = 1;
            else exp_q.push_back(v);
         end else if (q && !p) begin
            if (occ == 0) m_unf = 1;
            else void'(exp_q.pop_back());
         end else if (p && q) begin
            exp_q[exp_q.size() - 1] = v;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      bit acc, dst;
      for (int k = 0; k < n; k++) step(0, 0, '0, 0, acc, dst);
   endtask

   initial begin
      bit acc, dst;
      int i, j, guard, pu, po, r;
      bit p, q;
      logic [31:0] top_now;

      // reset state
      reset_dut();
      compare_state();
      check("rst_mem_we", 64'(mem_we), 64'(0));
      check("rst_mem_addr", 64'(mem_addr), 64'(0));
      check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
      check("rst_stall", 64'(stall), 64'(0));

      // first spill after six pushes
      for (int k = 0; k < 6; k++) step(1, 0, 32'(k), 0, acc, dst);
      idle(1);
      check("t1_req", 64'(mem_req), 64'(1));
      check("t1_we", 64'(mem_we), 64'(1));
      check("t1_addr", 64'(mem_addr), 64'(32'h100));
      check("t1_wdata", 64'(mem_wdata), 64'(0));
      idle(3);
      check("t1_occ", 64'(occupancy), 64'(5));
      check("t1_spilled", 64'(spilled), 64'(1));
      check("t1_top", 64'(tops[0]), 64'(5));

      // continuous push of 0..19 then pop all
      reset_dut();
      i = 0; guard = 0;
      while (i < 20 && guard < 300) begin
         step(1, 0, 32'(i), 0, acc, dst);
         if (dst) check("t2_stall_occ", 64'(s_occ), 64'(8));
         if (acc) i++;
         guard++;
      end
      check("t2_pushes", 64'(i), 64'(20));
      j = 0; guard = 0;
      while (j < 20 && guard < 400) begin
         top_now = tops[0];
         step(0, 1, '0, 0, acc, dst);
         if (acc) begin
            check("t2_pop_val", 64'(top_now), 64'(19 - j));
            j++;
         end
         guard++;
      end
      check("t2_pops", 64'(j), 64'(20));
      idle(2);
      check("t2_underflow", 64'(underflow), 64'(0));
      for (int k = 0; k < wr_addr_q.size(); k++) begin
         check("t2_wr_addr", 64'(wr_addr_q[k]), 64'(BASE + 32'(k)));
         check("t2_wr_data", 64'(wr_data_q[k]), 64'(k));
      end
      check("t2_rd_count", 64'(rd_addr_q.size()), 64'(wr_addr_q.size()));
      for (int k = 0; k < rd_addr_q.size(); k++)
         check("t2_rd_addr", 64'(rd_addr_q[k]), 64'(BASE + 32'(wr_addr_q.size() - 1 - k)));

      // memory never acks: buffer fills and stalls with the spill request held
      reset_dut();
      ack_en = 0; i = 0;
      for (int k = 0; k < 14; k++) begin
         step(1, 0, 32'(i), 0, acc, dst);
         if (acc) i++;
      end
      check("t3_accepted", 64'(i), 64'(8));
      check("t3_stall", 64'(dst), 64'(1));
      check("t3_occ", 64'(occupancy), 64'(8));
      check("t3_req", 64'(mem_req), 64'(1));
      check("t3_addr", 64'(mem_addr), 64'(32'h100));
      check("t3_wdata", 64'(mem_wdata), 64'(0));
      ack_en = 1;
      step(1, 0, 32'(i), 0, acc, dst);
      check("t3_hold", 64'(dst), 64'(1));
      step(1, 0, 32'(i), 0, acc, dst);
      check("t3_release", 64'(dst), 64'(0));
      if (acc) i++;
      guard = 0;
      while (i < 10 && guard < 50) begin
         step(1, 0, 32'(i), 0, acc, dst);
         if (acc) i++;
         guard++;
      end
      check("t3_pushes", 64'(i), 64'(10));
      idle(20);

      // push&pop replaces the top
      reset_dut();
      for (int k = 5; k < 8; k++) step(1, 0, 32'(k), 0, acc, dst);
      step(1, 1, 32'h55, 0, acc, dst);
      check("t4_top", 64'(tops[0]), 64'(32'h55));
      check("t4_below", 64'(tops[1]), 64'(6));
      check("t4_occ", 64'(occupancy), 64'(3));
      check("t4_req", 64'(mem_req), 64'(0));

      // pop on a truly empty stack
      reset_dut();
      step(0, 1, '0, 0, acc, dst);
      check("t5_stall", 64'(dst), 64'(0));
      check("t5_underflow", 64'(underflow), 64'(1));
      check("t5_occ", 64'(occupancy), 64'(0));
      idle(3);
      check("t5_underflow_sticky", 64'(underflow), 64'(1));

      // reset while a fill is outstanding; a late ack must be ignored
      reset_dut();
      lat = 1; i = 0; guard = 0;
      while (i < 10 && guard < 60) begin
         step(1, 0, 32'(i), 0, acc, dst);
         if (acc) i++;
         guard++;
      end
      idle(10);
      ack_en = 0; guard = 0;
      while (!(m_req && !m_we) && guard < 20) begin
         step(0, 1, '0, 0, acc, dst);
         guard++;
      end
      idle(1);
      check("t6_fill_req", 64'(mem_req), 64'(1));
      check("t6_fill_we", 64'(mem_we), 64'(0));
      check("t6_fill_addr", 64'(mem_addr), 64'(BASE + 32'(sp - 1)));
      #2;
      reset = 1'b1;
      #1;
      check("t6_rst_req", 64'(mem_req), 64'(0));
      check("t6_rst_occ", 64'(occupancy), 64'(0));
      check("t6_rst_spilled", 64'(spilled), 64'(0));
      @(negedge clk);
      reset = 1'b0;
      model_clear();
      step(0, 0, '0, 1, acc, dst);
      idle(2);
      check("t6_late_occ", 64'(occupancy), 64'(0));
      check("t6_late_spilled", 64'(spilled), 64'(0));
      check("t6_late_req", 64'(mem_req), 64'(0));

      // random traffic: push-heavy, pop-heavy, balanced
      reset_dut();
      rnd_lat = 1; spur = 1;
      for (int c = 0; c < 1800; c++) begin
         pu = (c < 600) ? 65 : (c < 1200) ? 20 : 40;
         po = (c < 600) ? 20 : (c < 1200) ? 65 : 40;
         r = $urandom_range(0, 99);
         p = 0; q = 0;
         if (r < pu) p = 1;
         else if (r < pu + po) q = 1;
         else if (r < pu + po + 10) begin
            p = 1;
            q = (m_occ() != 1);
         end
         step(p, q, $urandom(), 0, acc, dst);
      end
      spur = 0;
      idle(20);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
